// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the data-memory control encodings, FSM states and requester ids.
package mem_port_arbiter_pkg;

   localparam logic [2:0] DM_B  = 3'b000;
   localparam logic [2:0] DM_H  = 3'b001;
   localparam logic [2:0] DM_W  = 3'b010;
   localparam logic [2:0] DM_BU = 3'b100;
   localparam logic [2:0] DM_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Extend the low byte or half of v; sign bit is ignored when sgn=0.
   function automatic logic [31:0] load_extend(input logic [15:0] v,
                                               input logic half,
                                               input logic sgn);
      logic [31:0] r;
      if (half) r = {{16{sgn & v[15]}}, v};
      else      r = {{24{sgn & v[7]}}, v[7:0]};
      return r;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// Byte-lane steering for stores and lane select/extension for loads.
// Also flags misaligned accesses and illegal control codes.
module lsu_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0]  i_ctrl,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);
   logic [31:0] w_rshift;

   assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};

   always_comb begin
      o_be       = 4'b0000;
      o_wdata    = 32'h0;
      o_rdata    = 32'h0;
      o_misalign = 1'b0;
      case (i_ctrl)
         DM_B, DM_BU: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = load_extend(w_rshift[15:0], 1'b0, i_ctrl == DM_B);
         end
         DM_H, DM_HU: begin
            o_be       = 4'b0011 << i_addr_lo;
            o_wdata    = {2{i_wdata[15:0]}};
            o_rdata    = load_extend(w_rshift[15:0], 1'b1, i_ctrl == DM_H);
            o_misalign = i_addr_lo[0];
         end
         DM_W: begin
            o_be       = 4'b1111;
            o_wdata    = i_wdata;
            o_rdata    = w_rshift;
            o_misalign = |i_addr_lo;
         end
         default: o_misalign = 1'b1;
      endcase
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store,
// with data priority bounded by a starvation counter in favour of fetch.
//
// state    | meaning
// ST_IDLE  | no access outstanding; grant decided here (blocked while an rvalid pulse is out)
// ST_ISSUE | mem_req high, mem_* held until mem_ready
// ST_WAIT  | accepted, waiting for mem_rvalid
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   input  logic [2:0]        i_dm_ctrl,
   output logic              o_dm_rvalid,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_err,
   mem_port_arbiter_if.master mem,
   output logic              o_stall
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   state_e            r_state, w_state_nxt;
   owner_e            r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_be;
   logic [2:0]        r_ctrl;
   logic [1:0]        r_alo;
   logic [CNT_W-1:0]  r_starve;
   logic              r_if_rvalid, r_dm_rvalid, r_dm_err;
   logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

   logic              w_can_grant, w_grant_dm, w_grant_if, w_issue, w_done;
   logic [2:0]        w_ctrl;
   logic [1:0]        w_alo;
   logic [3:0]        w_lane_be;
   logic [31:0]       w_lane_wdata, w_lane_rdata;
   logic              w_lane_err;

   // In IDLE the aligner judges the incoming request; afterwards it extends the response.
   assign w_ctrl = (r_state == ST_IDLE) ? i_dm_ctrl       : r_ctrl;
   assign w_alo  = (r_state == ST_IDLE) ? i_dm_addr[1:0] : r_alo;

   lsu_lane_align u_align (
      .i_ctrl     (w_ctrl),
      .i_addr_lo  (w_alo),
      .i_wdata    (i_dm_wdata),
      .i_rdata    (mem.mem_rdata),
      .o_be       (w_lane_be),
      .o_wdata    (w_lane_wdata),
      .o_rdata    (w_lane_rdata),
      .o_misalign (w_lane_err)
   );

   // The requester still holds req during its rvalid cycle, so no grant then.
   assign w_can_grant = (r_state == ST_IDLE) & ~r_if_rvalid & ~r_dm_rvalid;
   assign w_grant_dm  = w_can_grant & i_dm_req & (r_starve < STARVE_LIM);
   assign w_grant_if  = w_can_grant & ~w_grant_dm & i_if_req;
   assign w_issue     = w_grant_if | (w_grant_dm & ~w_lane_err);
   assign w_done      = ((r_state == ST_ISSUE) & mem.mem_ready & mem.mem_rvalid) |
                        ((r_state == ST_WAIT) & mem.mem_rvalid);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_issue) w_state_nxt = ST_ISSUE;
         ST_ISSUE: if (mem.mem_ready) w_state_nxt = mem.mem_rvalid ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (mem.mem_rvalid) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_IF;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= 4'b0000;
         r_ctrl      <= 3'b000;
         r_alo       <= 2'b00;
         r_starve    <= '0;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rvalid <= 1'b0;
         r_dm_rdata  <= '0;
         r_dm_err    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rvalid <= 1'b0;
         r_dm_rdata  <= '0;
         r_dm_err    <= 1'b0;

         if (w_issue) begin
            r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
            r_we    <= w_grant_dm & i_dm_we;
            r_addr  <= w_grant_dm ? {i_dm_addr[ADDR_W-1:2], 2'b00}
                                  : {i_if_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= w_grant_dm ? w_lane_wdata : '0;
            r_be    <= w_grant_dm ? w_lane_be : 4'b1111;
            r_ctrl  <= i_dm_ctrl;
            r_alo   <= w_grant_dm ? i_dm_addr[1:0] : i_if_addr[1:0];
         end

         if (w_grant_dm & w_lane_err) begin
            r_dm_rvalid <= 1'b1;
            r_dm_err    <= 1'b1;
         end

         // A requester that dropped its req early gets no pulse; the result is discarded.
         if (w_done) begin
            if (r_owner == OWN_IF) begin
               r_if_rvalid <= i_if_req;
               r_if_rdata  <= i_if_req ? mem.mem_rdata : '0;
            end else begin
               r_dm_rvalid <= i_dm_req;
               r_dm_rdata  <= (i_dm_req & ~r_we) ? w_lane_rdata : '0;
            end
         end

         if (!i_if_req || w_grant_if) r_starve <= '0;
         else if (w_grant_dm && (r_starve < STARVE_LIM)) r_starve <= r_starve + 1'b1;
      end
   end

   assign mem.mem_req   = (r_state == ST_ISSUE);
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;
   assign mem.mem_be    = r_be;

   assign o_if_rvalid = r_if_rvalid;
   assign o_if_rdata  = r_if_rdata;
   assign o_dm_rvalid = r_dm_rvalid;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_dm_err    = r_dm_err;
   assign o_stall     = (i_if_req & ~r_if_rvalid) | (i_dm_req & ~r_dm_rvalid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory operations and
// responses are queued when a request is driven and popped as the DUT answers.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          o_if_rvalid;
   logic [DW-1:0] o_if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [2:0]    dm_ctrl = 3'b000;
   logic          o_dm_rvalid;
   logic [DW-1:0] o_dm_rdata;
   logic          o_dm_err;
   logic          o_stall;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_rvalid (o_if_rvalid),
      .o_if_rdata  (o_if_rdata),
      .i_dm_req    (dm_req),
      .i_dm_we     (dm_we),
      .i_dm_addr   (dm_addr),
      .i_dm_wdata  (dm_wdata),
      .i_dm_ctrl   (dm_ctrl),
      .o_dm_rvalid (o_dm_rvalid),
      .o_dm_rdata  (o_dm_rdata),
      .o_dm_err    (o_dm_err),
      .mem         (mem),
      .o_stall     (o_stall)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_op_t;

   typedef struct {
      logic        is_dm;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   mem_op_t exp_mem[$];
   rsp_t    exp_rsp[$];
   int      n_vec  = 0;
   int      n_miss = 0;
   int      n_hs   = 0;

   task automatic push_mem(input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata);
      mem_op_t m;
      m.addr = addr; m.we = we; m.be = be; m.wdata = wdata;
      exp_mem.push_back(m);
   endtask

   task automatic push_rsp(input logic is_dm, input logic err, input logic [31:0] rdata);
      rsp_t r;
      r.is_dm = is_dm; r.err = err; r.rdata = rdata;
      exp_rsp.push_back(r);
   endtask

   // Memory model: waits for mem_req, holds off mem_ready, then answers.
   task automatic serve(input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
      bit      found;
      mem_op_t e;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem.mem_req === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_vec++;
      if (!found) begin
         n_miss++;
         $display("FAIL serve_timeout: mem_req=%b required 1", mem.mem_req);
         return;
      end
      repeat (rdy_dly) @(negedge clk);
      n_hs++;
      if (exp_mem.size() == 0) begin
         n_miss++;
         $display("FAIL mem_unexpected: addr=%h required no access", mem.mem_addr);
      end else begin
         e = exp_mem.pop_front();
         if (mem.mem_req !== 1'b1 || mem.mem_addr !== e.addr || mem.mem_we !== e.we ||
             mem.mem_be !== e.be || (e.we && mem.mem_wdata !== e.wdata)) begin
            n_miss++;
            $display("FAIL mem_op: req=%b addr=%h we=%b be=%b wdata=%h required req=1 addr=%h we=%b be=%b wdata=%h",
                     mem.mem_req, mem.mem_addr, mem.mem_we, mem.mem_be, mem.mem_wdata,
                     e.addr, e.we, e.be, e.wdata);
         end
      end
      mem.mem_ready  = 1'b1;
      mem.mem_rdata  = rdata;
      mem.mem_rvalid = (rv_dly == 0);
      @(negedge clk);
      mem.mem_ready = 1'b0;
      if (rv_dly > 0) begin
         mem.mem_rvalid = 1'b0;
         repeat (rv_dly - 1) @(negedge clk);
         mem.mem_rvalid = 1'b1;
         @(negedge clk);
      end
      mem.mem_rvalid = 1'b0;
   endtask

   // Returns at the negedge where a response pulse is visible.
   task automatic wait_rsp(output int req_seen);
      bit   got;
      rsp_t e;
      got = 1'b0;
      req_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem.mem_req === 1'b1) req_seen++;
         if (o_if_rvalid === 1'b1 || o_dm_rvalid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_vec++;
      if (!got) begin
         n_miss++;
         $display("FAIL rsp_timeout: if_rvalid=%b dm_rvalid=%b required a pulse", o_if_rvalid, o_dm_rvalid);
      end else if (exp_rsp.size() == 0) begin
         n_miss++;
         $display("FAIL rsp_unexpected: if_rvalid=%b dm_rvalid=%b required none", o_if_rvalid, o_dm_rvalid);
      end else begin
         e = exp_rsp.pop_front();
         if (e.is_dm) begin
            if (o_dm_rvalid !== 1'b1 || o_if_rvalid !== 1'b0 || o_dm_err !== e.err || o_dm_rdata !== e.rdata) begin
               n_miss++;
               $display("FAIL dm_rsp: rvalid=%b if_rvalid=%b err=%b rdata=%h required rvalid=1 if_rvalid=0 err=%b rdata=%h",
                        o_dm_rvalid, o_if_rvalid, o_dm_err, o_dm_rdata, e.err, e.rdata);
            end
         end else begin
            if (o_if_rvalid !== 1'b1 || o_dm_rvalid !== 1'b0 || o_if_rdata !== e.rdata) begin
               n_miss++;
               $display("FAIL if_rsp: rvalid=%b dm_rvalid=%b rdata=%h required rvalid=1 dm_rvalid=0 rdata=%h",
                        o_if_rvalid, o_dm_rvalid, o_if_rdata, e.rdata);
            end
         end
      end
   endtask

   task automatic do_dm(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] mwdata,
                        input logic [31:0] mrdata, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly);
      int seen;
      dm_we = we; dm_ctrl = ctrl; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
      push_mem({addr[31:2], 2'b00}, we, be, mwdata);
      push_rsp(1'b1, 1'b0, rdata);
      serve(rdy_dly, rv_dly, mrdata);
      wait_rsp(seen);
      dm_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({o_if_rvalid, o_dm_rvalid, o_dm_err, o_stall, mem.mem_req, mem.mem_we} !== 6'b0 ||
          o_if_rdata !== 32'h0 || o_dm_rdata !== 32'h0 || mem.mem_addr !== 32'h0 ||
          mem.mem_wdata !== 32'h0 || mem.mem_be !== 4'h0) begin
         n_miss++;
         $display("FAIL reset_outputs: req=%b be=%b addr=%h stall=%b required all zero",
                  mem.mem_req, mem.mem_be, mem.mem_addr, o_stall);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch;
      int seen;
      if_addr = 32'h10;
      if_req  = 1'b1;
      push_mem(32'h10, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b0, 1'b0, 32'h00500093);
      @(negedge clk);
      n_vec++;
      if (o_stall !== 1'b1 || mem.mem_req !== 1'b1) begin
         n_miss++;
         $display("FAIL fetch_issue: stall=%b mem_req=%b required 1 1", o_stall, mem.mem_req);
      end
      serve(0, 2, 32'h00500093);
      wait_rsp(seen);
      n_vec++;
      if (o_stall !== 1'b0) begin
         n_miss++;
         $display("FAIL fetch_stall_release: stall=%b required 0", o_stall);
      end
      if_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (o_if_rvalid !== 1'b0 || o_stall !== 1'b0) begin
         n_miss++;
         $display("FAIL fetch_pulse_width: if_rvalid=%b stall=%b required 0 0", o_if_rvalid, o_stall);
      end
   endtask

   task automatic test_simultaneous;
      int seen;
      int hs0;
      hs0 = n_hs;
      if_addr = 32'h20; if_req = 1'b1;
      dm_we = 1'b0; dm_ctrl = DM_W; dm_addr = 32'h100; dm_wdata = 32'h0; dm_req = 1'b1;
      push_mem(32'h100, 1'b0, 4'hF, 32'h0);
      push_mem(32'h20, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b1, 1'b0, 32'h11111111);
      push_rsp(1'b0, 1'b0, 32'h22222222);
      serve(0, 1, 32'h11111111);
      wait_rsp(seen);
      dm_req = 1'b0;
      serve(1, 1, 32'h22222222);
      wait_rsp(seen);
      if_req = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (n_hs - hs0 != 2 || mem.mem_req !== 1'b0) begin
         n_miss++;
         $display("FAIL simul_handshakes: count=%0d mem_req=%b required 2 0", n_hs - hs0, mem.mem_req);
      end
   endtask

   task automatic test_starvation;
      int seen;
      if_addr = 32'h40; if_req = 1'b1;
      dm_we = 1'b0; dm_ctrl = DM_W; dm_wdata = 32'h0; dm_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dm_addr = 32'h500 + 32'(4 * k);
         push_mem(32'h500 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
         push_rsp(1'b1, 1'b0, 32'hA0 + 32'(k));
         serve(0, 1, 32'hA0 + 32'(k));
         wait_rsp(seen);
      end
      dm_addr = 32'h510;
      push_mem(32'h40, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b0, 1'b0, 32'h00000013);
      serve(0, 1, 32'h00000013);
      wait_rsp(seen);
      if_req = 1'b0;
      push_mem(32'h510, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b1, 1'b0, 32'hA4);
      serve(0, 1, 32'hA4);
      wait_rsp(seen);
      dm_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (exp_mem.size() != 0 || exp_rsp.size() != 0) begin
         n_miss++;
         $display("FAIL starve_drain: mem_q=%0d rsp_q=%0d required 0 0", exp_mem.size(), exp_rsp.size());
      end
   endtask

   task automatic test_stores;
      do_dm(1'b1, DM_B, 32'h203, 32'h000000AB, 4'b1000, 32'hABABABAB, 32'hFFFFFFFF, 32'h0, 0, 0);
      do_dm(1'b1, DM_H, 32'h302, 32'h00001234, 4'b1100, 32'h12341234, 32'hFFFFFFFF, 32'h0, 2, 1);
      do_dm(1'b1, DM_W, 32'h300, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 0, 2);
   endtask

   task automatic test_loads;
      do_dm(1'b0, DM_H,  32'h302, 32'h0, 4'b1100, 32'h0, 32'h80F0FF7F, 32'hFFFF80F0, 1, 1);
      do_dm(1'b0, DM_HU, 32'h302, 32'h0, 4'b1100, 32'h0, 32'h80F0FF7F, 32'h000080F0, 1, 1);
      do_dm(1'b0, DM_B,  32'h300, 32'h0, 4'b0001, 32'h0, 32'h80F0FF7F, 32'h0000007F, 1, 1);
      do_dm(1'b0, DM_BU, 32'h301, 32'h0, 4'b0010, 32'h0, 32'h80F0FF7F, 32'h000000FF, 0, 0);
      do_dm(1'b0, DM_B,  32'h301, 32'h0, 4'b0010, 32'h0, 32'h80F0FF7F, 32'hFFFFFFFF, 0, 1);
      do_dm(1'b0, DM_B,  32'h303, 32'h0, 4'b1000, 32'h0, 32'h80F0FF7F, 32'hFFFFFF80, 1, 0);
      do_dm(1'b0, DM_W,  32'h300, 32'h0, 4'b1111, 32'h0, 32'h80F0FF7F, 32'h80F0FF7F, 0, 1);
   endtask

   task automatic test_errors;
      logic [2:0]  ctrls [3];
      logic [31:0] addrs [3];
      int          seen;
      ctrls[0] = DM_W;   addrs[0] = 32'h401;
      ctrls[1] = DM_H;   addrs[1] = 32'h203;
      ctrls[2] = 3'b011; addrs[2] = 32'h400;
      for (int k = 0; k < 3; k++) begin
         dm_we = 1'b0; dm_ctrl = ctrls[k]; dm_addr = addrs[k]; dm_req = 1'b1;
         push_rsp(1'b1, 1'b1, 32'h0);
         wait_rsp(seen);
         dm_req = 1'b0;
         @(negedge clk);
         n_vec++;
         if (seen != 0 || mem.mem_req !== 1'b0) begin
            n_miss++;
            $display("FAIL err_no_access: case=%0d mem_req_cycles=%0d required 0", k, seen);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit found;
      bit stray;
      int seen;
      found = 1'b0;
      stray = 1'b0;
      dm_we = 1'b0; dm_ctrl = DM_W; dm_addr = 32'h600; dm_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem.mem_req === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!found) begin
         n_miss++;
         $display("FAIL rstmid_issue: mem_req=%b required 1", mem.mem_req);
      end
      mem.mem_ready = 1'b1;
      @(negedge clk);
      mem.mem_ready = 1'b0;
      rst = 1'b1;
      dm_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({o_if_rvalid, o_dm_rvalid, o_dm_err, o_stall, mem.mem_req, mem.mem_we} !== 6'b0 ||
          o_if_rdata !== 32'h0 || o_dm_rdata !== 32'h0 || mem.mem_addr !== 32'h0 ||
          mem.mem_wdata !== 32'h0 || mem.mem_be !== 4'h0) begin
         n_miss++;
         $display("FAIL rstmid_outputs: req=%b addr=%h be=%b dm_rvalid=%b required all zero",
                  mem.mem_req, mem.mem_addr, mem.mem_be, o_dm_rvalid);
      end
      rst = 1'b0;
      mem.mem_rdata  = 32'h12345678;
      mem.mem_rvalid = 1'b1;
      @(negedge clk);
      mem.mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (o_if_rvalid || o_dm_rvalid || mem.mem_req) stray = 1'b1;
         @(negedge clk);
      end
      n_vec++;
      if (stray) begin
         n_miss++;
         $display("FAIL rstmid_late_rvalid: stray activity=1 required 0");
      end
      if_addr = 32'h80; if_req = 1'b1;
      push_mem(32'h80, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b0, 1'b0, 32'h0BADF00D);
      serve(0, 1, 32'h0BADF00D);
      wait_rsp(seen);
      if_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      mem.mem_ready  = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata  = '0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_starvation();
      test_stores();
      test_loads();
      test_errors();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency memory between the core's instruction-fetch path and its load/store path. Arbitrates between the two, sequences each access as a request/ready/rvalid transaction, and applies byte-lane steering and load extension from the data-memory control code. It also drives a stall that freezes the PC and register-file write until the current instruction's accesses complete.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; fixed at 32 (four byte lanes)
STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; on reaching it, the next grant goes to fetch

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_rvalid
if_addr  in  ADDR_W  fetch address (word aligned)
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request, level, held until dm_rvalid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  byte address
dm_wdata  in  DATA_W  store data, right-aligned
dm_ctrl  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
dm_rvalid  out  1  one-cycle pulse, load data or store completion
dm_rdata  out  DATA_W  extended load data; 0 for stores
dm_err  out  1  qualifies dm_rvalid; misaligned access or illegal dm_ctrl
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word address (bits [1:0] forced to 0)
mem_wdata  out  DATA_W  lane-steered store data
mem_be  out  4  byte enables
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response or write acknowledge
mem_rdata  in  DATA_W  raw read word
stall  out  1  core must hold its state

Behaviour:
- Reset: state IDLE; all outputs 0; starvation counter 0. Reset mid-transaction abandons it, and any later mem_rvalid is ignored until a new issue.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE. Only one transaction is outstanding at any time.
- IDLE: if dm_req and the starvation counter is below STARVE_MAX, grant data; otherwise, if if_req, grant fetch; otherwise stay in IDLE. Grant, owner, address, we, wdata and be are registered on the grant edge.
- Data legality is checked at grant time:
  - h/hu with addr[0]=1 is misaligned.
  - w with addr[1:0]!=0 is misaligned.
  - Codes 011, 110 and 111 are illegal.
  - On any error: no memory access; dm_rvalid=1 and dm_err=1 on the next cycle; return to IDLE.
- ISSUE: mem_req=1, with mem_* outputs held stable until the cycle mem_ready=1, then go to WAIT. mem_rvalid in the same cycle as mem_ready is legal; the transaction completes then.
- WAIT: on mem_rvalid, pulse the owner's rvalid for one cycle with its rdata, then go to IDLE. Next grant is at the earliest one cycle later.
- Store steering:
  - b: be = 0001 << a[1:0]; byte replicated to all lanes.
  - h: be = 0011 << a[1:0]; half replicated to both halves.
  - w: be = 1111.
- Load extension: select the byte or half by a[1:0]; sign-extend for b/h, zero-extend for bu/hu.
- Starvation counter:
  - +1 on each data grant while if_req=1.
  - Cleared on any fetch grant, or when if_req=0.
  - Saturates at STARVE_MAX.
- stall = (if_req & ~if_rvalid) | (dm_req & ~dm_rvalid), combinational.
- Simultaneous if_req and dm_req in IDLE: data wins unless starvation is forced.
- A requester dropping its req before rvalid is a protocol violation; the arbiter still completes the transaction and discards the result.

Decomposition:
- Shared package: dm_ctrl encodings (DM_B, DM_H, DM_W, DM_BU, DM_HU), the FSM state enum, and the owner enum (OWN_IF, OWN_DM).
- Sub-module lsu_lane_align (combinational): dm_ctrl, addr[1:0], wdata, rdata -> be, steered wdata, extended rdata, misalign flag.
- The FSM, grant logic and counter stay in the top module.

Test Plan:
- Fetch only: if_addr=0x10; mem_ready on cycle 1, mem_rvalid on cycle 3 with 0x00500093 -> if_rvalid pulse with if_rdata=0x00500093; stall high until that cycle; mem_addr=0x10, mem_be=1111.
- Simultaneous requests: if_req and dm_req (lw at 0x100) -> data granted first, then fetch; exactly two mem_req handshakes.
- Starvation: if_req held, dm_req back-to-back, STARVE_MAX=4 -> fetch granted after the 4th data grant.
- Store byte: sb at 0x203, wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x200; dm_rdata=0.
- Loads: mem_rdata=0x80F0FF7F at addr 0x302 -> lh gives 0xFFFF80F0, lhu gives 0x000080F0, lb at 0x300 gives 0x0000007F.
- Error and reset: lw at 0x401 -> dm_err=1, no mem_req. Reset asserted in WAIT -> all outputs 0, late mem_rvalid ignored.
